// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
// Imported by fetch_buffer and fetch_pipe_front.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries; clear beats push/pop.
// Push while full is accepted only alongside a pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= nxt(wr_ptr);
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pipe_front.sv
// Fetch front end: PCF, imem requests, buffer, IF/ID.
// Define FETCH_BYPASS_EN to let responses skip the buffer.
module fetch_pipe_front
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2,
  parameter int          CNT_W     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        fetch_err
);

  logic [31:0]      pcf;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] pend_count;
  logic [CNT_W:0]   credit;
  fetch_entry_t     buf_head;
  fetch_entry_t     pend_head;
  fetch_entry_t     pend_din;
  fetch_entry_t     rsp_entry;
  logic             buf_empty;
  logic             buf_full;
  logic             pend_empty;
  logic             pend_full;
  logic             req_fire;
  logic             rsp_ok;
  logic             rsp_keep;
  logic             buf_push;
  logic             buf_pop;
  logic             bypass;
  logic             unused_ok;

  // Credits cover both in-flight and buffered words.
  assign credit = {1'b0, outstanding}
                + {1'b0, buf_count};

  assign imem_req_valid = !reset && !PCSrcE
                       && !StallF
                       && (credit < (CNT_W+1)'(BUF_DEPTH));
  assign imem_req_addr  = pcf;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign rsp_ok   = imem_rsp_valid
                 && (outstanding != '0);
  assign rsp_keep = rsp_ok && !PCSrcE
                 && (drop_cnt == '0);

  assign rsp_entry = '{pc: pend_head.pc,
                       instr: imem_rsp_data};
  assign pend_din  = '{pc: pcf, instr: '0};

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && buf_empty
               && !StallD && !FlushD;
`else
  assign bypass = 1'b0;
`endif

  assign buf_push = rsp_keep && !bypass;
  assign buf_pop  = !FlushD && !StallD
                 && !PCSrcE && !buf_empty;

  assign unused_ok = &{1'b0, pend_head.instr,
                       pend_count, pend_empty,
                       pend_full, buf_full};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_pend (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_ok),
    .clear (1'b0),
    .din   (pend_din),
    .dout  (pend_head),
    .count (pend_count),
    .empty (pend_empty),
    .full  (pend_full)
  );

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (PCSrcE),
    .din   (rsp_entry),
    .dout  (buf_head),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf         <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (PCSrcE)
        pcf <= PCTargetE;
      else if (req_fire)
        pcf <= pcf + 32'd4;
      outstanding <= outstanding
                   + CNT_W'(req_fire)
                   - CNT_W'(rsp_ok);
      // Everything still in flight is wrong-path.
      if (PCSrcE)
        drop_cnt <= outstanding - CNT_W'(rsp_ok);
      else if (rsp_ok && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
      if (imem_rsp_valid && outstanding == '0)
        fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd4;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (bypass) begin
        InstrD   <= rsp_entry.instr;
        PCD      <= rsp_entry.pc;
        PCPlus4D <= rsp_entry.pc + 32'd4;
        ValidD   <= 1'b1;
      end else if (buf_pop) begin
        InstrD   <= buf_head.instr;
        PCD      <= buf_head.pc;
        PCPlus4D <= buf_head.pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pipe_front.sv
// Directed bench for fetch_pipe_front with a variable-latency
// in-order instruction memory model.
module tb_fetch_pipe_front;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  int nv0;
  int max_out = 0;
  int cyc = 0;
  int lat = 1;
  logic force_rsp = 1'b0;
  logic found;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_pipe_front #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .CNT_W     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(
    input logic [31:0] a
  );
    return a + 32'h0001_0033;
  endfunction

  // Memory: a word accepted in cycle c returns in c+lat.
  logic        hs;
  logic [31:0] ha;
  always @(posedge clk) begin
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    cyc++;
    #2;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (reset) begin
      mq.delete();
    end else begin
      if (hs)
        mq.push_back('{ha, cyc - 1 + lat});
      if (mq.size() > max_out)
        max_out = mq.size();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq[0].a);
        void'(mq.pop_front());
      end
    end
    if (force_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (ValidD) begin
        nvalid++;
        chk("seq_pcd", PCD, exp_pc);
        chk("seq_instr", InstrD,
            instr_of(exp_pc));
        chk("seq_pc4", PCPlus4D,
            exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    repeat (3) step();

    chk("rst_valid", 32'(ValidD), 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_pc4", PCPlus4D, 4);
    chk("rst_err", 32'(fetch_err), 0);
    chk("rst_req", 32'(imem_req_valid), 0);

    // Straight line, 1-cycle memory.
    reset = 1'b0;
    #1;
    chk("c0_req", 32'(imem_req_valid), 1);
    chk("c0_addr", imem_req_addr, 0);
    step();
    chk("c0_valid", 32'(ValidD), 0);
    chk("c1_addr", imem_req_addr, 4);
    step();
`ifdef FETCH_BYPASS_EN
    chk("first_valid", 32'(ValidD), 1);
`else
    chk("c1_valid", 32'(ValidD), 0);
    step();
    chk("first_valid", 32'(ValidD), 1);
`endif
    chk("first_pcd", PCD, 0);
    chk("first_instr", InstrD, instr_of(0));
    chk("first_pc4", PCPlus4D, 4);
    exp_pc = 32'd4;
    watch(20);

    // 3-cycle memory: credit caps in-flight at 2.
    lat = 3;
    max_out = 0;
    nv0 = nvalid;
    watch(30);
    chk("max_out", max_out, 2);
    chk("progress", 32'(nvalid - nv0 >= 6), 1);

    StallF = 1'b1;
    watch(12);
    chk("drain_valid", 32'(ValidD), 0);
    chk("drain_req", 32'(imem_req_valid), 0);
    chk("drain_pcf", imem_req_addr, exp_pc);

    // Redirect with two requests in flight.
    StallF = 1'b0;
    step();
    step();
    chk("cred_full", 32'(imem_req_valid), 0);
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    FlushD = 1'b1;
    step();
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    #1;
    chk("redir_pcf", imem_req_addr, 32'h100);
    chk("redir_noreq", 32'(imem_req_valid), 0);
    chk("redir_bubble", 32'(ValidD), 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = ValidD;
    end
    chk("redir_found", 32'(found), 1);
    chk("redir_pcd", PCD, 32'h100);
    chk("redir_pc4", PCPlus4D, 32'h104);
    chk("redir_instr", InstrD,
        instr_of(32'h100));

    // StallD until the buffer fills, then hold 4 more.
    StallD = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pcd", PCD, 32'h100);
      chk("stall_instr", InstrD,
          instr_of(32'h100));
      chk("stall_req", 32'(imem_req_valid), 0);
    end
    chk("stall_pcf", imem_req_addr, 32'h10C);
    StallD = 1'b0;
    step();
    chk("rel0_valid", 32'(ValidD), 1);
    chk("rel0_pcd", PCD, 32'h104);
    step();
    chk("rel1_valid", 32'(ValidD), 1);
    chk("rel1_pcd", PCD, 32'h108);
    chk("rel1_instr", InstrD,
        instr_of(32'h108));

    // FlushD beats StallD.
    FlushD = 1'b1;
    StallD = 1'b1;
    step();
    FlushD = 1'b0;
    StallD = 1'b0;
    chk("fs_valid", 32'(ValidD), 0);
    chk("fs_instr", InstrD, NOP);
    chk("fs_pcd", PCD, 32'h108);
    exp_pc = 32'h10C;
    watch(20);

    // Unsolicited response with nothing in flight.
    StallF = 1'b1;
    watch(12);
    chk("idle_valid", 32'(ValidD), 0);
    chk("idle_pcf", imem_req_addr, exp_pc);
    chk("idle_err", 32'(fetch_err), 0);
    force_rsp = 1'b1;
    step();
    force_rsp = 1'b0;
    chk("spur_err", 32'(fetch_err), 1);
    chk("spur_valid", 32'(ValidD), 0);
    chk("spur_pcf", imem_req_addr, exp_pc);
    StallF = 1'b0;
    nv0 = nvalid;
    watch(15);
    chk("spur_progress",
        32'(nvalid - nv0 >= 3), 1);
    chk("err_sticky", 32'(fetch_err), 1);

    reset = 1'b1;
    step();
    chk("rst2_err", 32'(fetch_err), 0);
    chk("rst2_valid", 32'(ValidD), 0);
    chk("rst2_instr", InstrD, NOP);
    chk("rst2_pcd", PCD, 0);
    chk("rst2_pcf", imem_req_addr, 0);
    chk("rst2_req", 32'(imem_req_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
